gpio_pulse_driver: RTL and testbench

Output-side counterpart to the debounced GPIO button input path. It drives one GPIO header pin with a burst of N clean, fixed-width pulses on command, for external LEDs, buzzers or a second board's button input. Pulse high and low widths are long enough to survive the receiving side's debounce. Instantiated in the DE2_115 top level, with the output tied to a GPIO pin and triggered by on-board keys or internal logic.

---
 rtl/gpio_pulse_driver.sv | 148 ++++++++++++++
 tb/tb_gpio_pulse_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pulse_driver.sv
// -----------------------------------------------------------------------------
// gpio_pulse_driver
//
// Drives one GPIO pin with a burst of N fixed-width pulses on command. Each
// pulse is HIGH_CYC cycles at the active level (~IDLE_LEVEL), followed by
// LOW_CYC cycles at IDLE_LEVEL. The trailing gap of the last pulse always
// elapses before completion is signalled. The widths are long enough that a
// debounced receiver sees every edge.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_start      burst request, honoured only while idle
//   i_count      number of pulses, latched together with i_start
//   i_abort      stop the current burst on the next edge (no o_done)
//   o_gpio       registered pin drive
//   o_busy       high while a burst is in progress
//   o_done       one-cycle strobe on normal completion (or a zero-length request)
//   o_remaining  pulses whose active phase has not yet finished
// -----------------------------------------------------------------------------
module gpio_pulse_driver #(
  parameter int unsigned HIGH_CYC   = 12500000,
  parameter int unsigned LOW_CYC    = 12500000,
  parameter int unsigned CNT_W      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic             i_abort,
  output logic             o_gpio,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_remaining
);

  localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] LOW_LAST  = TMR_W'(LOW_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } state_e;

  state_e             state_q,     state_d;
  logic [TMR_W-1:0]   timer_q,     timer_d;
  logic               gpio_q,      gpio_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;

  logic               start_zero;

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; blocking here would create
  // order-dependent simulation and a mismatch with the synthesized flops.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gpio_q      <= IDLE_LEVEL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gpio_q      <= gpio_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = '0;  // timer restarts on every phase change and stays 0 in idle
    case (state_q)
      ST_IDLE: begin
        // Abort in the same cycle as start drops the request.
        if (i_start && !i_abort && (i_count != '0)) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (timer_q == HIGH_LAST) begin
          state_d = ST_LOW;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_LOW: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (timer_q == LOW_LAST) begin
          // o_remaining was already decremented when this pulse went low.
          state_d = (remaining_q != '0) ? ST_HIGH : ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: computes the next value of each registered output
  // ---------------------------------------------------------------------------
  assign start_zero = (state_q == ST_IDLE) && i_start && !i_abort && (i_count == '0);

  always_comb begin
    gpio_d      = (state_d == ST_HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
    busy_d      = (state_d != ST_IDLE);
    // A zero-length request completes at once; an abort never signals done.
    done_d      = start_zero ||
                  ((state_q == ST_LOW) && (state_d == ST_IDLE) && !i_abort);
    remaining_d = remaining_q;
    if ((state_q == ST_IDLE) && (state_d == ST_HIGH)) begin
      remaining_d = i_count;
    end else if (state_d == ST_IDLE) begin
      remaining_d = '0;
    end else if ((state_q == ST_HIGH) && (state_d == ST_LOW)) begin
      // Only reached with remaining_q >= 1, so this cannot wrap.
      remaining_d = remaining_q - CNT_W'(1);
    end
  end

  assign o_gpio      = gpio_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_remaining = remaining_q;

endmodule

// File: tb/tb_gpio_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_gpio_pulse_driver
//
// Directed bench for gpio_pulse_driver. Instance a uses HIGH_CYC=3, LOW_CYC=2,
// CNT_W=4, IDLE_LEVEL=0; instance b is identical except IDLE_LEVEL=1. Inputs
// change 1 ns after a rising edge and outputs are sampled at that same point,
// so each sample shows the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_gpio_pulse_driver;

  localparam int PER = 5;  // HIGH_CYC + LOW_CYC

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start_a, abort_a;
  logic [3:0] count_a;
  logic       gpio_a, busy_a, done_a;
  logic [3:0] rem_a;

  logic       start_b, abort_b;
  logic [3:0] count_b;
  logic       gpio_b, busy_b, done_b;
  logic [3:0] rem_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_pulse_driver #(
    .HIGH_CYC(3), .LOW_CYC(2), .CNT_W(4), .IDLE_LEVEL(1'b0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_count(count_a),
    .i_abort(abort_a), .o_gpio(gpio_a), .o_busy(busy_a), .o_done(done_a),
    .o_remaining(rem_a)
  );

  gpio_pulse_driver #(
    .HIGH_CYC(3), .LOW_CYC(2), .CNT_W(4), .IDLE_LEVEL(1'b1)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_count(count_b),
    .i_abort(abort_b), .o_gpio(gpio_b), .o_busy(busy_b), .o_done(done_b),
    .o_remaining(rem_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for instance a, k cycles after the start edge of an n-pulse burst.
  function automatic logic exp_gpio(int k);
    return ((k % PER) < 3);
  endfunction

  function automatic logic [3:0] exp_rem(int n, int k);
    return 4'(n - (k / PER) - (((k % PER) >= 3) ? 1 : 0));
  endfunction

  task automatic check_burst_a(input string tag, input int n, input int k);
    check({tag, " gpio"}, 32'(gpio_a), 32'(exp_gpio(k)));
    check({tag, " busy"}, 32'(busy_a), 32'd1);
    check({tag, " rem"},  32'(rem_a),  32'(exp_rem(n, k)));
    check({tag, " done"}, 32'(done_a), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; count_a = 4'd0;
    start_b = 1'b0; abort_b = 1'b0; count_b = 4'd0;

    // ---- reset held two cycles ----
    tick();
    tick();
    check("rst gpio_a", 32'(gpio_a), 32'd0);
    check("rst busy_a", 32'(busy_a), 32'd0);
    check("rst done_a", 32'(done_a), 32'd0);
    check("rst rem_a",  32'(rem_a),  32'd0);
    check("rst gpio_b", 32'(gpio_b), 32'd1);
    rst_n = 1'b1;
    tick();

    // ---- 1: two-pulse burst ----
    start_a = 1'b1; count_a = 4'd2;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 2 * PER; k++) begin
      check_burst_a("t1", 2, k);
      tick();
    end
    check("t1 end done", 32'(done_a), 32'd1);
    check("t1 end busy", 32'(busy_a), 32'd0);
    check("t1 end gpio", 32'(gpio_a), 32'd0);
    check("t1 end rem",  32'(rem_a),  32'd0);
    tick();
    check("t1 done off", 32'(done_a), 32'd0);

    // ---- 2: zero-length request ----
    start_a = 1'b1; count_a = 4'd0;
    tick();
    start_a = 1'b0;
    check("t2 done", 32'(done_a), 32'd1);
    check("t2 busy", 32'(busy_a), 32'd0);
    check("t2 gpio", 32'(gpio_a), 32'd0);
    tick();
    check("t2 done off", 32'(done_a), 32'd0);
    check("t2 busy off", 32'(busy_a), 32'd0);

    // ---- 3: start during a burst is ignored ----
    start_a = 1'b1; count_a = 4'd3;
    tick();
    for (int k = 0; k < 3 * PER; k++) begin
      check_burst_a("t3", 3, k);
      start_a = (k == 6);
      count_a = (k == 6) ? 4'd7 : 4'd3;
      tick();
    end
    check("t3 end done", 32'(done_a), 32'd1);
    check("t3 end busy", 32'(busy_a), 32'd0);
    tick();
    check("t3 done off", 32'(done_a), 32'd0);
    check("t3 idle rem", 32'(rem_a),  32'd0);

    // ---- 4: abort in the second cycle of pulse 2 ----
    start_a = 1'b1; count_a = 4'd5;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check_burst_a("t4", 5, k);
      abort_a = (k == 6);
      tick();
    end
    abort_a = 1'b0;
    check("t4 abort gpio", 32'(gpio_a), 32'd0);
    check("t4 abort busy", 32'(busy_a), 32'd0);
    check("t4 abort rem",  32'(rem_a),  32'd0);
    check("t4 abort done", 32'(done_a), 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t4 no done", 32'(done_a), 32'd0);
    end

    // ---- maximum count is latched without wrap, then aborted ----
    start_a = 1'b1; count_a = 4'd15;
    tick();
    start_a = 1'b0;
    check("max rem", 32'(rem_a), 32'd15);
    tick(); tick(); tick();
    check("max rem dec", 32'(rem_a), 32'd14);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("max abort busy", 32'(busy_a), 32'd0);

    // ---- 5a: start and abort together in idle ----
    start_a = 1'b1; abort_a = 1'b1; count_a = 4'd3;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("t5 sa busy", 32'(busy_a), 32'd0);
    check("t5 sa gpio", 32'(gpio_a), 32'd0);
    check("t5 sa done", 32'(done_a), 32'd0);
    tick();
    check("t5 sa busy2", 32'(busy_a), 32'd0);

    // ---- 5b: reset mid-HIGH ----
    start_a = 1'b1; count_a = 4'd3;
    tick();
    start_a = 1'b0;
    tick();
    check("t5 pre-rst gpio", 32'(gpio_a), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t5 rst gpio", 32'(gpio_a), 32'd0);
    check("t5 rst busy", 32'(busy_a), 32'd0);
    check("t5 rst rem",  32'(rem_a),  32'd0);
    check("t5 rst done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5 post done", 32'(done_a), 32'd0);
    check("t5 post busy", 32'(busy_a), 32'd0);

    // ---- 6: inverted idle level, back-to-back bursts ----
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("t6 idle abort gpio", 32'(gpio_b), 32'd1);
    start_b = 1'b1; count_b = 4'd1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < PER; k++) begin
      check("t6 gpio", 32'(gpio_b), (k < 3) ? 32'd0 : 32'd1);
      check("t6 busy", 32'(busy_b), 32'd1);
      check("t6 done", 32'(done_b), 32'd0);
      tick();
    end
    check("t6 end done", 32'(done_b), 32'd1);
    check("t6 end busy", 32'(busy_b), 32'd0);
    check("t6 end gpio", 32'(gpio_b), 32'd1);
    start_b = 1'b1; count_b = 4'd1;
    tick();
    start_b = 1'b0;
    check("t6 restart busy", 32'(busy_b), 32'd1);
    check("t6 restart gpio", 32'(gpio_b), 32'd0);
    check("t6 restart rem",  32'(rem_b),  32'd1);
    check("t6 restart done", 32'(done_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
